// File: rtl/bcd_display_sched_pkg.sv
// Shared types and constants for the BCD display scheduler and its divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bcd_display_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DISPLAY = 2'd2
  } sched_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t       BLANK_DIGIT = 4'hF;
  localparam logic [1:0] PLACE_MSD   = 2'd2;
  localparam int         DIV_ITERS   = 16;

  // Places count down hundreds -> tens -> units, then wrap back to hundreds.
  function automatic logic [1:0] next_place(input logic [1:0] place);
    return (place == 2'd0) ? PLACE_MSD : place - 2'd1;
  endfunction

endpackage

// File: rtl/bcd_display_scheduler_divmod10.sv
// Serial restoring divide-by-10 of a 16-bit dividend, one quotient bit per clock.
// Latency: start to done is exactly 16 clocks; done is a one-cycle pulse.
// Backpressure: none; a start while busy restarts the division.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start, dividend       launch a division of dividend (sampled with start)
//   done                  one-cycle pulse, quotient/remainder valid from then on
//   quotient, remainder   dividend / 10 and dividend % 10 (remainder 0..9)
module divmod10
  import bcd_display_sched_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] dividend,
  output logic        done,
  output logic [15:0] quotient,
  output logic [3:0]  remainder
);

  logic        active;
  logic [3:0]  iter_cnt;
  logic [3:0]  src_rem;
  logic [15:0] src_quo;
  logic [4:0]  trial;
  logic        qbit;
  logic [3:0]  nxt_rem;
  logic [15:0] nxt_quo;

  // The first iteration runs on the start edge straight from the dividend,
  // so 16 iterations finish one edge before done is raised.
  always_comb begin
    src_rem = start ? 4'd0 : remainder;
    src_quo = start ? dividend : quotient;
    // Partial remainder stays below 10, so the trial value never exceeds 19.
    trial   = {src_rem, src_quo[15]};
    qbit    = (trial >= 5'd10);
    nxt_rem = qbit ? 4'(trial - 5'd10) : trial[3:0];
    nxt_quo = {src_quo[14:0], qbit};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active    <= 1'b0;
      iter_cnt  <= 4'd0;
      done      <= 1'b0;
      quotient  <= 16'd0;
      remainder <= 4'd0;
    end else begin
      done <= 1'b0;
      if (start) begin
        remainder <= nxt_rem;
        quotient  <= nxt_quo;
        iter_cnt  <= 4'd1;
        active    <= 1'b1;
      end else if (active) begin
        remainder <= nxt_rem;
        quotient  <= nxt_quo;
        iter_cnt  <= iter_cnt + 4'd1;
        if (iter_cnt == 4'(DIV_ITERS - 1)) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_display_scheduler.sv
// Shares one 3-digit decimal display between two 16-bit sources (round-robin).
// Latency: accept at cycle 0, new digits on display at cycle 52.
// Backpressure: valid/ready; ready is a one-cycle accept, granted from IDLE at once or at frame end in DISPLAY.
//
// Ports:
//   clock, reset               rising-edge clock, synchronous active-high reset
//   valid_0/1, value_0/1       requests and binary values from the two sources
//   ready_0/1                  one-cycle accept pulse back to each source
//   digit, digit_place         BCD digit shown (4'hF = blank) and its place (2=hundreds)
//   src                        source owning the displayed digits
//   busy                       high while digits are being extracted
//   overflow                   the displayed value was above 999
// Build option: BCD_SCHED_OVERFLOW_BLANK_EN blanks all places for values above 999;
// without it the low three decimal digits are shown.
module bcd_display_scheduler
  import bcd_display_sched_pkg::*;
#(
  parameter int DWELL_POW2 = 14
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_0,
  input  logic        valid_1,
  input  logic [15:0] value_0,
  input  logic [15:0] value_1,
  output logic        ready_0,
  output logic        ready_1,
  output logic [3:0]  digit,
  output logic [1:0]  digit_place,
  output logic        src,
  output logic        busy,
  output logic        overflow
);

  localparam logic [DWELL_POW2-1:0] DWELL_ONE = 1;

  sched_state_t           state_q, state_d;
  logic                   last_q;
  logic                   src_q;
  logic [15:0]            work_q;
  logic [1:0]             step_q;
  bcd_t                   d0_q, d1_q;
  logic [2:0][3:0]        disp_q;
  logic                   overflow_q;
  logic [DWELL_POW2-1:0]  dwell_q;
  logic [1:0]             place_q;
  logic                   kick_q;

  logic                   div_done;
  logic [15:0]            div_quo;
  logic [3:0]             div_rem;

  logic                   any_req;
  logic                   grant;
  logic                   grant_sel;
  logic                   dwell_end;
  logic                   frame_end;
  logic                   enter_disp;
  logic                   conv_ovf;
  logic [2:0][3:0]        new_disp;

  divmod10 u_divmod10 (
    .clock     (clock),
    .reset     (reset),
    .start     (kick_q),
    .dividend  (work_q),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign any_req   = valid_0 | valid_1;
  // A lone requester wins outright; on a tie the source that did not go last wins.
  assign grant_sel = (valid_0 && valid_1) ? ~last_q : valid_1;
  assign dwell_end = &dwell_q;
  assign frame_end = dwell_end && (place_q == 2'd0);

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    enter_disp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant   = 1'b1;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (div_done && step_q == 2'd2) begin
          enter_disp = 1'b1;
          state_d    = ST_DISPLAY;
        end
      end
      ST_DISPLAY: begin
        // The owner keeps the display for whole frames only.
        if (frame_end && any_req) begin
          grant   = 1'b1;
          state_d = ST_CONVERT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A reset cycle must never look like an accept to a source.
  assign ready_0 = grant && !reset && !grant_sel;
  assign ready_1 = grant && !reset &&  grant_sel;

  // Third pass: remainder is the hundreds digit; a non-zero quotient means > 999.
  always_comb begin
    conv_ovf = (div_quo != 16'd0);
    new_disp = {div_rem, d1_q, d0_q};
`ifdef BCD_SCHED_OVERFLOW_BLANK_EN
    if (conv_ovf) new_disp = {BLANK_DIGIT, BLANK_DIGIT, BLANK_DIGIT};
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      src_q      <= 1'b0;
      work_q     <= 16'd0;
      step_q     <= 2'd0;
      d0_q       <= 4'd0;
      d1_q       <= 4'd0;
      disp_q     <= {BLANK_DIGIT, BLANK_DIGIT, BLANK_DIGIT};
      overflow_q <= 1'b0;
      dwell_q    <= '0;
      place_q    <= PLACE_MSD;
      kick_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // Each divider pass starts the cycle after the previous one reports done.
      kick_q  <= grant || (state_q == ST_CONVERT && div_done && step_q != 2'd2);

      if (grant) begin
        last_q <= grant_sel;
        src_q  <= grant_sel;
        work_q <= grant_sel ? value_1 : value_0;
        step_q <= 2'd0;
      end

      if (state_q == ST_CONVERT && div_done) begin
        work_q <= div_quo;
        case (step_q)
          2'd0: begin
            d0_q   <= div_rem;
            step_q <= 2'd1;
          end
          2'd1: begin
            d1_q   <= div_rem;
            step_q <= 2'd2;
          end
          default: begin
            disp_q     <= new_disp;
            overflow_q <= conv_ovf;
            step_q     <= 2'd0;
          end
        endcase
      end

      // A fresh value always starts its first frame on the hundreds place.
      if (enter_disp) begin
        dwell_q <= '0;
        place_q <= PLACE_MSD;
      end else begin
        dwell_q <= dwell_q + DWELL_ONE;
        if (dwell_end) place_q <= next_place(place_q);
      end
    end
  end

  always_comb begin
    digit = BLANK_DIGIT;
    case (place_q)
      2'd2:    digit = disp_q[2];
      2'd1:    digit = disp_q[1];
      2'd0:    digit = disp_q[0];
      default: digit = BLANK_DIGIT;
    endcase
  end

  assign digit_place = place_q;
  assign src         = src_q;
  assign busy        = (state_q == ST_CONVERT);
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Self-checking bench for bcd_display_scheduler with a transaction-level model.
// Latency: n/a.
// Backpressure: sources hold valid until ready, occasionally abandoning a request.
module tb_bcd_display_scheduler;

  localparam int DW = 2;
`ifdef BCD_SCHED_OVERFLOW_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_0, valid_1;
  logic [15:0] value_0, value_1;
  logic        ready_0, ready_1;
  logic [3:0]  digit;
  logic [1:0]  digit_place;
  logic        src, busy, overflow;

  bcd_display_scheduler #(.DWELL_POW2(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .valid_0     (valid_0),
    .valid_1     (valid_1),
    .value_0     (value_0),
    .value_1     (value_1),
    .ready_0     (ready_0),
    .ready_1     (ready_1),
    .digit       (digit),
    .digit_place (digit_place),
    .src         (src),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // tk   : cycles since reset or since the latest value reached the display
  // age  : cycles since accept while a value is being converted, 0 otherwise
  int tk, age, pend;
  bit showing, m_last, m_src, m_ovf, model_on;
  int m_dig[3];
  bit saw_r0, saw_r1;

  always @(negedge clock) begin
    int pl;
    bit g;
    int sel;
    if (reset) begin
      chk("ready_0_in_reset", ready_0, 0);
      chk("ready_1_in_reset", ready_1, 0);
      tk = 0; age = 0; showing = 0; m_last = 1; m_src = 0; m_ovf = 0;
      for (int i = 0; i < 3; i++) m_dig[i] = 15;
      saw_r0 = 0; saw_r1 = 0;
      model_on = 1;
    end else if (model_on) begin
      pl  = 2 - (tk / 4) % 3;
      g   = (age == 0) && (!showing || (tk % 12) == 11) && (valid_0 || valid_1);
      sel = (valid_0 && valid_1) ? int'(!m_last) : int'(valid_1);
      chk("ready_0", ready_0, int'(g && sel == 0));
      chk("ready_1", ready_1, int'(g && sel == 1));
      chk("busy", busy, int'(age > 0));
      chk("digit_place", digit_place, pl);
      chk("digit", digit, m_dig[pl]);
      chk("src", src, m_src);
      chk("overflow", overflow, m_ovf);
      saw_r0 = ready_0;
      saw_r1 = ready_1;
      if (g) begin
        m_src = sel[0]; m_last = sel[0];
        pend = (sel == 1) ? int'(value_1) : int'(value_0);
        age = 1; tk++;
      end else if (age > 0) begin
        if (age == 51) begin
          m_ovf = (pend > 999);
          if (BLANK_EN && m_ovf) begin
            for (int i = 0; i < 3; i++) m_dig[i] = 15;
          end else begin
            m_dig[0] = pend % 10;
            m_dig[1] = (pend / 10) % 10;
            m_dig[2] = (pend / 100) % 10;
          end
          tk = 0; showing = 1; age = 0;
        end else begin
          age++; tk++;
        end
      end else begin
        tk++;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(input int s, input int budget);
    int n = 0;
    while (((s == 0) ? ready_0 : ready_1) !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("ready_%0d_within_%0d", s, budget), int'(((s == 0) ? ready_0 : ready_1) === 1'b1), 1);
  endtask

  // Call at the negedge of the accept cycle; returns at the negedge of the frame's last cycle.
  task automatic conv_frame(input int s, input int d2, input int d1, input int d0, input int ovf);
    int nb = 0;
    tick(1);
    if (s == 0) valid_0 = 1'b0; else valid_1 = 1'b0;
    for (int i = 0; i < 51; i++) begin
      @(negedge clock);
      nb += int'(busy);
    end
    chk("busy_cycles", nb, 51);
    @(negedge clock);
    chk("busy_after_convert", busy, 0);
    chk("src_on_display", src, s);
    chk("overflow_on_display", overflow, ovf);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clock);
      chk("frame_place", digit_place, 2 - i / 4);
      chk("frame_digit", digit, (i < 4) ? d2 : (i < 8) ? d1 : d0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_pl[12] = '{2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0};
    int nr;
    int ovd;
    reset = 1'b1; valid_0 = 1'b0; valid_1 = 1'b0; value_0 = '0; value_1 = '0;
    tick(3);
    reset = 1'b0;

    // Scenario 1: idle, blank display cycling through the places
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk("s1_place", digit_place, exp_pl[i]);
      chk("s1_blank", digit, 15);
      chk("s1_no_ready", int'(ready_0 | ready_1), 0);
    end

    // Scenario 2: single request 472
    tick(1);
    valid_0 = 1'b1; value_0 = 16'd472;
    @(negedge clock);
    chk("s2_ready_0_immediate", ready_0, 1);
    conv_frame(0, 4, 7, 2, 0);

    // Scenario 3: simultaneous requests after reset, source 0 first
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    valid_0 = 1'b1; value_0 = 16'd123;
    valid_1 = 1'b1; value_1 = 16'd456;
    @(negedge clock);
    chk("s3_tie_not_src1", ready_1, 0);
    wait_ready(0, 1);
    conv_frame(0, 1, 2, 3, 0);
    wait_ready(1, 0);
    conv_frame(1, 4, 5, 6, 0);

    // Scenario 4: overflow
    tick(1);
    valid_1 = 1'b1; value_1 = 16'd65535;
    @(negedge clock);
    wait_ready(1, 20);
    ovd = BLANK_EN ? 15 : 5;
    conv_frame(1, ovd, BLANK_EN ? 15 : 3, ovd, 1);

    // Scenario 6: zero clears overflow; abandoned request gets no ready
    tick(1);
    valid_0 = 1'b1; value_0 = 16'd0;
    @(negedge clock);
    wait_ready(0, 20);
    conv_frame(0, 0, 0, 0, 0);
    tick(2);
    valid_1 = 1'b1; value_1 = 16'd777;
    nr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      nr += int'(ready_1);
    end
    tick(0);
    @(posedge clock);
    #1;
    valid_1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      nr += int'(ready_1);
    end
    chk("s6_abandoned_no_ready_1", nr, 0);

    // Scenario 5: reset in the middle of a conversion
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    valid_0 = 1'b1; value_0 = 16'd999;
    @(negedge clock);
    wait_ready(0, 1);
    tick(1);
    valid_0 = 1'b0;
    tick(19);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clock);
    chk("s5_idle_not_busy", busy, 0);
    chk("s5_blank", digit, 15);
    chk("s5_place_msd", digit_place, 2);
    chk("s5_overflow_clear", overflow, 0);
    tick(1);
    valid_1 = 1'b1; value_1 = 16'd305;
    @(negedge clock);
    wait_ready(1, 1);
    conv_frame(1, 3, 0, 5, 0);

    // Random traffic checked by the model on every cycle
    for (int c = 0; c < 5000; c++) begin
      tick(1);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 699) == 0) reset = 1'b1;
      for (int s = 0; s < 2; s++) begin
        logic v;
        logic r;
        logic [15:0] nv;
        v = (s == 0) ? valid_0 : valid_1;
        r = (s == 0) ? saw_r0 : saw_r1;
        nv = '0;
        case ($urandom_range(0, 5))
          0: nv = 16'($urandom_range(0, 65535));
          1: nv = 16'd999;
          2: nv = 16'd1000;
          default: nv = 16'($urandom_range(0, 999));
        endcase
        if (v) begin
          if (r || $urandom_range(0, 199) == 0) v = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          v = 1'b1;
          if (s == 0) value_0 = nv; else value_1 = nv;
        end
        if (s == 0) valid_0 = v; else valid_1 = v;
      end
    end
    tick(1);
    reset = 1'b0; valid_0 = 1'b0; valid_1 = 1'b0;
    tick(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_display_scheduler.md
# bcd_display_scheduler

Shares one three-digit decimal display between two 16-bit value sources. It arbitrates the sources round-robin and sequences a shared serial divide-by-10 unit to extract the digits. It then time-multiplexes the digits onto a single 4-bit digit bus with a place index, for the seven-segment drive logic downstream.

## Interface
- `DWELL_POW2`, default 14: each digit is shown for 2^DWELL_POW2 clocks.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `valid_0`, `valid_1`  in  1  request from source 0 or 1.
- `value_0`, `value_1`  in  16  binary value from source 0 or 1.
- `ready_0`, `ready_1`  out  1  one-cycle accept pulse to source 0 or 1.
- `digit`  out  4  BCD digit currently shown; 4'hF means blank.
- `digit_place`  out  2  place index: 2 = hundreds, 1 = tens, 0 = units.
- `src`  out  1  source that owns the digits on display.
- `busy`  out  1  high while in CONVERT.
- `overflow`  out  1  the displayed value exceeded 999.

## Operation
- The state machine has three states: IDLE, CONVERT and DISPLAY.
- Reset values:
  - state = IDLE, `digit` = 4'hF, `digit_place` = 2.
  - `src` = 0, `ready_*` = 0, `busy` = 0, `overflow` = 0.
  - Round-robin pointer `last` = 1, so source 0 wins the first tie.
  - The dwell counter is 0 and the divider is idle.
- IDLE:
  - Display is blank: `digit` = 4'hF and `digit_place` cycles 2→1→0 at the dwell rate.
  - If any `valid_*` is high, grant it.
- Grant:
  - If one source is valid, that source is granted. If both are valid, the source ≠ `last` is granted.
  - The grant pulses its `ready` for one cycle and latches its value. `src` and `last` become the granted source.
  - State goes to CONVERT.
- Request rules:
  - A source must hold `valid` and `value` stable until its `ready` pulses.
  - If `valid` drops before the grant, no transfer happens.
  - `value` is sampled only in the `ready` cycle.
- CONVERT:
  - The divider is run three times: v%10 gives d0, then q%10 gives d1, then q'%10 gives d2.
  - The final quotient q'' ≠ 0 sets the overflow flag.
  - The digits are held in a shadow register. Display registers update only on entry to DISPLAY.
  - The previous digits, or blank, keep cycling during CONVERT.
- DISPLAY:
  - Digits are shown in order d2, d1, d0, each for 2^DWELL_POW2 cycles. One such pass is a frame.
  - At the end of each frame (units dwell expiring), the grant check runs.
  - If a request is pending, it is granted and the FSM moves to CONVERT.
  - Otherwise the same frame repeats.
- Sources are never preempted mid-frame.
- Arithmetic:
  - The divider is restoring, 16 bits wide, and produces one quotient bit per cycle.
  - Remainder is 4 bits, always 0–9. Quotient is 16 bits. Intermediate quotients are truncated to 16 bits.

## Timing
- Accept (`ready` pulse) happens at cycle 0.
- Divider starts are at cycles 1, 18 and 35. Done pulses are at cycles 17, 34 and 51. The divider latency from `start` to `done` is exactly 16 cycles.
- The next start is issued the cycle after each `done`.
- Cycle 52: state is DISPLAY, `digit_place` = 2, `digit` = d2, and the dwell counter is cleared.
- `busy` is high from cycle 1 through cycle 51 inclusive.
- A request arriving mid-frame is accepted in the cycle the frame's last dwell expires. Worst-case wait is 3·2^DWELL_POW2 cycles.
- `valid_*` changes during CONVERT are ignored.
- Reset asserted in any state, including mid-conversion, returns all state to reset values on the next edge. The divider is aborted and no `ready` pulse is issued.
- The dwell counter wraps from all-ones to 0 and advances `digit_place`. Place wrap is 0→2.

## Configuration
- `BCD_SCHED_OVERFLOW_BLANK_EN`
  - Defined: a value above 999 displays 4'hF on all three places and `overflow` = 1.
  - Undefined: the low three decimal digits (value mod 1000) are displayed and `overflow` = 1 still.
- In both cases `overflow` clears when a value ≤ 999 reaches DISPLAY.

## Structure
- Package `bcd_display_sched_pkg` holds:
  - the state enum (IDLE, CONVERT, DISPLAY);
  - `BLANK_DIGIT` = 4'hF;
  - `PLACE_MSD` = 2'd2;
  - the divider iteration count, 16.
- Sub-module `divmod10` is the 16-cycle restoring divide-by-10.
  - Inputs: `start`, 16-bit dividend.
  - Outputs: one-cycle `done`, 16-bit quotient, 4-bit remainder.
  - It shares `clock` and `reset`.
- The top level contains the FSM, the round-robin arbiter and the dwell/place counter.

## Test plan
- Use DWELL_POW2 = 2 for all scenarios.
- Scenario 1: reset, no requests → `digit` = F, `digit_place` cycles 2,1,0 every 4 clocks, `ready_*` stay 0.
- Scenario 2: `valid_0` with 16'd472 → `ready_0` at cycle 0, `busy` for cycles 1–51, then digits 4,7,2 on places 2,1,0, `src` = 0, repeating each frame.
- Scenario 3: `valid_0` and `valid_1` together (123 and 456) → source 0 granted first. Source 1 is granted at the end of the first display frame and shows 4,5,6 with `src` = 1.
- Scenario 4: value 16'd65535 → `overflow` = 1. Display shows F,F,F with the macro defined and 5,3,5 without it.
- Scenario 5: reset pulsed at cycle 20 of CONVERT → next cycle is IDLE with blank display, and a later request converts correctly.
- Scenario 6: value 0 → digits 0,0,0 and `overflow` = 0. `valid_1` dropped before its grant → no `ready_1` pulse.
